// File: rtl/ram_z_stream_reader.sv
// rtl/ram_z_stream_reader.sv - streams LENGTH consecutive z-vector RAM words out as valid/ready beats
// A 2-entry buffer plus one in-flight read hides the RAM's registered read latency.
module ram_z_stream_reader #(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_qin,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_count;
   logic              inflight;
   logic [ADDR_W:0]   issue_cnt;
   logic [ADDR_W:0]   beat_cnt;
   logic              pop;
   logic              issue;
   logic [2:0]        occ;

   assign ram_we  = 1'b0;
   assign ram_qin = '0;
   assign m_valid = (fifo_count != 2'd0);
   assign m_data  = fifo_mem[rd_ptr];
   assign m_last  = m_valid && (beat_cnt == (ADDR_W+1)'(1));

   // Credit check counts the word already in flight so the buffer can never overflow.
   always_comb begin
      pop   = m_valid & m_ready;
      occ   = {1'b0, fifo_count} + {2'b00, inflight};
      issue = (state == S_READ) && (issue_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_address <= '0;
         issue_cnt   <= '0;
         beat_cnt    <= '0;
         inflight    <= 1'b0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (inflight) begin
            fifo_mem[wr_ptr] <= ram_data_out;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            beat_cnt <= beat_cnt - (ADDR_W+1)'(1);
         end
         fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

         inflight <= issue;
         if (issue) begin
            ram_address <= ram_address + ADDR_W'(1);
            issue_cnt   <= issue_cnt - (ADDR_W+1)'(1);
         end

         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (length == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state       <= S_READ;
                     busy        <= 1'b1;
                     ram_address <= base_addr;
                     issue_cnt   <= length;
                     beat_cnt    <= length;
                  end
               end
            end
            S_READ: begin
               if (pop && m_last) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_z_stream_reader.sv
// tb/tb_ram_z_stream_reader.sv - directed table-driven bench for ram_z_stream_reader
// RAM model returns mem[i] = i one clock after the address is sampled.
module tb_ram_z_stream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [17:0] base_addr;
   logic [18:0] length;
   logic        busy;
   logic        done;
   logic [17:0] ram_address;
   logic        ram_we;
   logic [31:0] ram_qin;
   logic [31:0] ram_data_out;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [17:0] base;
      logic [18:0] len;
      logic [15:0] pat;
      logic        poke;
      int          exp_span;
   } vec_t;

   ram_z_stream_reader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .ram_address(ram_address), .ram_we(ram_we),
      .ram_qin(ram_qin), .ram_data_out(ram_data_out), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ram_data_out <= {14'd0, ram_address};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_xfer(input vec_t v);
      int          cyc;
      int          beats;
      int          first;
      int          lastc;
      int          naddr;
      int          ndone;
      int          lead_max;
      logic [17:0] prev_addr;
      logic [17:0] lead;
      logic [17:0] ea;
      logic        held;
      logic [31:0] held_data;
      logic        held_last;
      @(negedge clk);
      base_addr = v.base; length = v.len; start = 1'b1; m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; beats = 0; first = -1; lastc = 0; held = 1'b0; lead_max = 0;
      held_data = '0; held_last = 1'b0;
      check("first_addr", {14'd0, ram_address}, {14'd0, v.base});
      prev_addr = ram_address; naddr = 1;
      while (beats < int'(v.len) && cyc < 300) begin
         if (v.poke && cyc == 2) begin
            start = 1'b1; base_addr = 18'd50; length = 19'd3;
         end else begin
            start = 1'b0;
         end
         if (ram_address != prev_addr) begin
            if (naddr < int'(v.len)) begin
               ea = v.base + 18'(naddr);
               check("addr_seq", {14'd0, ram_address}, {14'd0, ea});
               naddr++;
            end
            prev_addr = ram_address;
         end
         lead = ram_address - v.base - 18'(beats);
         if (int'(lead) > lead_max) lead_max = int'(lead);
         if (held) begin
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_data", m_data, held_data);
            check("hold_last", {31'd0, m_last}, {31'd0, held_last});
         end
         if (m_valid && first < 0) begin
            first = cyc;
            check("first_latency", first, 3);
            check("busy_active", {31'd0, busy}, 32'd1);
         end
         m_ready = (first < 0) ? 1'b0 : v.pat[(cyc - first) % 16];
         if (m_valid && m_ready) begin
            ea = v.base + 18'(beats);
            check("beat_data", m_data, {14'd0, ea});
            check("beat_last", {31'd0, m_last}, {31'd0, (beats == int'(v.len) - 1)});
            beats++;
            lastc = cyc;
         end
         held = m_valid && !m_ready;
         held_data = m_data;
         held_last = m_last;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      m_ready = 1'b0;
      check("beats_delivered", beats, int'(v.len));
      check("beat_span", lastc - first + 1, v.exp_span);
      check("addr_count", naddr, int'(v.len));
      check("lead_max_le2", {31'd0, (lead_max <= 2)}, 32'd1);
      check("done_pulse", {31'd0, done}, 32'd1);
      check("busy_after", {31'd0, busy}, 32'd0);
      check("valid_after", {31'd0, m_valid}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || busy || m_valid) ndone++;
      end
      check("no_extra_activity", ndone, 0);
   endtask

   initial begin
      vec_t        vecs [5];
      logic [17:0] addr_before;
      int          beats;
      int          extra;

      vecs[0] = '{18'd10,     19'd4, 16'hFFFF, 1'b0, 4};
      vecs[1] = '{18'd0,      19'd8, 16'hD369, 1'b0, 15};
      vecs[2] = '{18'd262142, 19'd4, 16'hFFFF, 1'b0, 4};
      vecs[3] = '{18'd5,      19'd3, 16'h5555, 1'b0, 5};
      vecs[4] = '{18'd30,     19'd5, 16'hFFFF, 1'b1, 5};

      rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_valid", {31'd0, m_valid}, 32'd0);
      check("rst_last", {31'd0, m_last}, 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_addr", {14'd0, ram_address}, 32'd0);
      check("ram_we", {31'd0, ram_we}, 32'd0);
      check("ram_qin", ram_qin, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

      // zero-length transfer
      addr_before = ram_address;
      base_addr = 18'd77; length = 19'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("len0_done", {31'd0, done}, 32'd1);
      check("len0_busy", {31'd0, busy}, 32'd0);
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         if (m_valid || ram_address != addr_before) extra++;
         @(negedge clk);
      end
      check("len0_quiet", extra, 0);
      check("len0_done_clear", {31'd0, done}, 32'd0);

      // reset in the middle of a transfer
      base_addr = 18'd100; length = 19'd16; start = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      beats = 0;
      for (int i = 0; i < 50 && beats < 3; i++) begin
         if (m_valid && m_ready) begin
            check("pre_rst_data", m_data, 32'd100 + beats);
            beats++;
         end
         if (beats < 3) @(negedge clk);
      end
      check("pre_rst_beats", beats, 3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
      check("mid_rst_last", {31'd0, m_last}, 32'd0);
      check("mid_rst_data", m_data, 32'd0);
      check("mid_rst_addr", {14'd0, ram_address}, 32'd0);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_valid || busy || done) extra++;
      end
      check("mid_rst_no_stale", extra, 0);
      m_ready = 1'b0;
      run_xfer('{18'd200, 19'd2, 16'hFFFF, 1'b0, 2});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
